// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: default timing constants and repeat-FSM states shared by the button conditioner.
package button_conditioner_pkg;
  localparam int DEF_DEBOUNCE_CYCLES = 40000;
  localparam int DEF_REPEAT_DELAY = 2000000;
  localparam int DEF_REPEAT_PERIOD = 500000;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;
endpackage

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw pushbutton inputs and conditioned pulse/level outputs.
interface button_conditioner_if;
  logic btn_set;
  logic btn_up;
  logic btn_down;
  logic set;
  logic up;
  logic down;
  logic held;
  modport master(output btn_set, btn_up, btn_down, input set, up, down, held);
  modport slave(input btn_set, btn_up, btn_down, output set, up, down, held);
endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchronizer, debounce counter and rising-edge detect for one button.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d, prev_q, diff, done;
  always_comb begin
    diff = sync_q[1] ^ level_q;
    done = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = diff && !done ? cnt_q + 1'b1 : '0;
    level_d = level_q ^ done;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      cnt_q <= cnt_d;
      level_q <= level_d;
      prev_q <= level_q;
    end
  end
  assign level = level_q;
  assign rise = level_q & ~prev_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces SET/UP/DOWN and produces single SET pulses plus auto-repeating UP/DOWN pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input logic clkBoard,
  input logic reset,
  button_conditioner_if.slave bus
);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [2:0] btn, lvl, rise;
  logic [1:0] ud_lvl, ud_rise, pulse_d;
  rep_state_e st_q [2];
  rep_state_e st_d [2];
  logic [RW-1:0] cnt_q [2];
  logic [RW-1:0] cnt_d [2];
  logic conflict, set_d, set_q, held_d, held_q, up_q, down_q;
  assign btn = {bus.btn_down, bus.btn_up, bus.btn_set};
  for (genvar i = 0; i < 3; i++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clkBoard),
      .rst(reset),
      .din(btn[i]),
      .level(lvl[i]),
      .rise(rise[i])
    );
  end
  assign ud_lvl = lvl[2:1];
  assign ud_rise = rise[2:1];
  // Conflict parks both FSMs in IDLE; only a fresh rise can restart one afterwards.
  always_comb begin
    conflict = &ud_lvl;
    set_d = rise[0] & lvl[0];
    held_d = ud_lvl[0] ^ ud_lvl[1];
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
      cnt_d[i] = cnt_q[i] + 1'b1;
      pulse_d[i] = 1'b0;
      if (conflict || !ud_lvl[i]) begin
        st_d[i] = IDLE;
        cnt_d[i] = '0;
      end else begin
        case (st_q[i])
          IDLE: begin
            cnt_d[i] = '0;
            if (ud_rise[i]) begin
              st_d[i] = DELAY;
              pulse_d[i] = 1'b1;
            end
          end
          DELAY: if (cnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
            st_d[i] = REPEAT;
            cnt_d[i] = '0;
            pulse_d[i] = 1'b1;
          end
          default: if (cnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
            cnt_d[i] = '0;
            pulse_d[i] = 1'b1;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clkBoard) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= IDLE;
        cnt_q[i] <= '0;
      end
      set_q <= 1'b0;
      up_q <= 1'b0;
      down_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i] <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      set_q <= set_d;
      up_q <= pulse_d[0] & ~pulse_d[1];
      down_q <= pulse_d[1] & ~pulse_d[0];
      held_q <= held_d;
    end
  end
  assign bus.set = set_q;
  assign bus.up = up_q;
  assign bus.down = down_q;
  assign bus.held = held_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus against a time-history reference model.
module tb_button_conditioner;
  localparam int DEB = 4, RD = 10, RP = 3, N = 4096;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0, bad = 0, t = 0, rst_t = 0, base = 0;
  bit raw_h [3][N];
  bit lv [3][N];
  bit act [2];
  int pt [2];
  logic prev_set = 1'b0;
  int q_set[$], q_up[$], q_dn[$], w[$];
  button_conditioner_if ifc();
  button_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clkBoard(clk),
    .reset(rst),
    .bus(ifc)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, t);
    end
  endtask

  // synchronized sample visible after edge x: raw value taken one edge earlier, zero right after reset
  function automatic bit samp(int c, int x);
    return (x > rst_t + 1) ? raw_h[c][x-1] : 1'b0;
  endfunction

  task automatic step(input logic [2:0] b, input logic r);
    bit e_set, e_held;
    bit [1:0] e_rep;
    ifc.btn_set = b[0];
    ifc.btn_up = b[1];
    ifc.btn_down = b[2];
    rst = r;
    @(posedge clk);
    #1;
    t++;
    for (int c = 0; c < 3; c++) raw_h[c][t] = b[c];
    e_set = 0;
    e_held = 0;
    e_rep = '0;
    if (r) begin
      rst_t = t;
      for (int c = 0; c < 3; c++) lv[c][t] = 0;
      act[0] = 0;
      act[1] = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        bit tog;
        tog = 1;
        for (int k = 1; k <= DEB; k++) if (samp(c, t - k) == lv[c][t-1]) tog = 0;
        lv[c][t] = lv[c][t-1] ^ tog;
      end
      e_set = lv[0][t-1] & !lv[0][t-2];
      e_held = lv[1][t-1] ^ lv[2][t-1];
      for (int d = 0; d < 2; d++) begin
        if ((lv[1][t-1] && lv[2][t-1]) || !lv[d+1][t-1]) act[d] = 0;
        else if (act[d]) e_rep[d] = (t - pt[d] >= RD) && ((t - pt[d] - RD) % RP == 0);
        else if (!lv[d+1][t-2]) begin
          act[d] = 1;
          pt[d] = t;
          e_rep[d] = 1;
        end
      end
    end
    check("set", ifc.set, e_set);
    check("up", ifc.up, e_rep[0]);
    check("down", ifc.down, e_rep[1]);
    check("held", ifc.held, e_held);
    check("up_and_down", ifc.up & ifc.down, 0);
    check("set_twice", ifc.set & prev_set, 0);
    prev_set = ifc.set;
    if (ifc.set === 1'b1) q_set.push_back(t - base);
    if (ifc.up === 1'b1) q_up.push_back(t - base);
    if (ifc.down === 1'b1) q_dn.push_back(t - base);
  endtask

  task automatic start();
    q_set.delete();
    q_up.delete();
    q_dn.delete();
    base = t + 1;
  endtask

  task automatic expect_list(input string tag, input int got[$], input int want[$]);
    check({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++) check(tag, got[i], want[i]);
  endtask

  initial begin
    logic [2:0] cur;
    int hold [3];
    // SET held: one pulse only
    start();
    step(3'b001, 1);
    repeat (50) step(3'b001, 0);
    repeat (5) step(3'b000, 0);
    w = '{7};
    expect_list("s1_set", q_set, w);
    w.delete();
    expect_list("s1_up", q_up, w);
    expect_list("s1_down", q_dn, w);
    // UP chattering shorter than the debounce window
    start();
    step(3'b000, 1);
    for (int j = 1; j < 40; j++) step({1'b0, ((j / 2) % 2) == 1, 1'b0}, 0);
    repeat (20) step(3'b000, 0);
    w.delete();
    expect_list("s2_up", q_up, w);
    expect_list("s2_set", q_set, w);
    // UP held then released: press, delay, repeat, clean stop
    start();
    for (int j = 0; j < 60; j++) step({1'b0, j < 40, 1'b0}, j == 0);
    w = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44};
    expect_list("s3_up", q_up, w);
    // UP held, DOWN joins: lockout until UP is re-pressed
    start();
    for (int j = 0; j < 90; j++)
      step({j >= 13 && j < 30, j < 45 || (j >= 50 && j < 80), 1'b0}, j == 0);
    w = '{7, 17, 56, 66, 69, 72, 75, 78, 81, 84};
    expect_list("s4_up", q_up, w);
    w.delete();
    expect_list("s4_down", q_dn, w);
    // DOWN held across a mid-repeat reset
    start();
    for (int j = 0; j < 40; j++) begin
      step(3'b100, j == 0 || j == 18);
      if (j == 18) check("s5_reset_outs", {ifc.set, ifc.up, ifc.down, ifc.held}, 0);
    end
    w = '{7, 17, 25, 35, 38};
    expect_list("s5_down", q_dn, w);
    // random bursts with occasional resets
    step(3'b000, 1);
    cur = '0;
    for (int c = 0; c < 3; c++) hold[c] = 0;
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (hold[c] == 0) begin
          cur[c] = 1'($urandom_range(0, 1));
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 6));
        end
        hold[c]--;
      end
      step(cur, $urandom_range(0, 299) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
